// File: rtl/transp_light_ctrl.sv
// Two-road traffic-light controller with all-red clearance, latched pedestrian
// walk phase, south-north car sensor hold and flashing-yellow night mode.
module transp_light_ctrl #(
  parameter int CLK_DIV   = 50000000,
  parameter int GREEN_EW  = 30,
  parameter int GREEN_NS  = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1,
  parameter int PED_T     = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             night_mode,
  input  logic             ped_req,
  input  logic             car_ns,
  output logic [1:0]       e_west,
  output logic [1:0]       s_north,
  output logic             ped_walk,
  output logic [CNT_W-1:0] remain,
  output logic             ped_pend
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_GRN = 2'b01;
  localparam logic [1:0] L_YEL = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

  typedef enum logic [2:0] {
    AR_A, AR_B, EW_G, EW_Y, NS_G, NS_Y, PED_WALK, FLASH
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             flash_q, flash_d;
  logic             ped_pend_q, ped_pend_d;
  logic [1:0]       e_west_q, e_west_d;
  logic [1:0]       s_north_q, s_north_d;
  logic             ped_walk_q, ped_walk_d;
  logic             tick;
  logic             ped_clr;

  function automatic logic [CNT_W-1:0] ld(input int dur);
    return CNT_W'(dur - 1);
  endfunction

  // With CLK_DIV=1 the counter never leaves 0, so every cycle is a tick.
  always_comb begin
    tick   = (pcnt_q == PW'(CLK_DIV - 1));
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flash_d  = flash_q;
    ped_clr  = 1'b0;
    if (tick) begin
      if (state_q == FLASH) begin
        flash_d = ~flash_q;
        if (!night_mode) begin
          state_d  = AR_B;
          remain_d = ld(ALL_RED_T);
        end
      end else if (remain_q != '0) begin
        remain_d = remain_q - 1'b1;
      end else begin
        case (state_q)
          AR_B: begin
            if (night_mode) begin
              state_d  = FLASH;
              remain_d = '0;
              flash_d  = 1'b1;
            end else if (ped_pend_q) begin
              state_d  = PED_WALK;
              remain_d = ld(PED_T);
              ped_clr  = 1'b1;
            end else begin
              state_d  = EW_G;
              remain_d = ld(GREEN_EW);
            end
          end
          // East-west green is the rest state: it holds at remain=0 until
          // someone else needs the intersection.
          EW_G: begin
            if (car_ns || ped_pend_q || night_mode) begin
              state_d  = EW_Y;
              remain_d = ld(YELLOW_T);
            end
          end
          EW_Y:     begin state_d = AR_A; remain_d = ld(ALL_RED_T); end
          AR_A:     begin state_d = NS_G; remain_d = ld(GREEN_NS);  end
          NS_G:     begin state_d = NS_Y; remain_d = ld(YELLOW_T);  end
          NS_Y:     begin state_d = AR_B; remain_d = ld(ALL_RED_T); end
          PED_WALK: begin state_d = EW_G; remain_d = ld(GREEN_EW);  end
          default:  begin state_d = AR_B; remain_d = ld(ALL_RED_T); end
        endcase
      end
    end
    // A new press in the same cycle as service must not be lost.
    ped_pend_d = ped_req | (ped_pend_q & ~ped_clr);
  end

  // Lamps are decoded from the next state so the registered outputs line up
  // with the registered state.
  always_comb begin
    e_west_d   = L_RED;
    s_north_d  = L_RED;
    ped_walk_d = 1'b0;
    case (state_d)
      EW_G:     e_west_d   = L_GRN;
      EW_Y:     e_west_d   = L_YEL;
      NS_G:     s_north_d  = L_GRN;
      NS_Y:     s_north_d  = L_YEL;
      PED_WALK: ped_walk_d = 1'b1;
      FLASH: begin
        e_west_d  = flash_d ? L_YEL : L_OFF;
        s_north_d = flash_d ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= AR_B;
      pcnt_q     <= '0;
      remain_q   <= ld(ALL_RED_T);
      flash_q    <= 1'b0;
      ped_pend_q <= 1'b0;
      e_west_q   <= L_RED;
      s_north_q  <= L_RED;
      ped_walk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      remain_q   <= remain_d;
      flash_q    <= flash_d;
      ped_pend_q <= ped_pend_d;
      e_west_q   <= e_west_d;
      s_north_q  <= s_north_d;
      ped_walk_q <= ped_walk_d;
    end
  end

  assign e_west   = e_west_q;
  assign s_north  = s_north_q;
  assign ped_walk = ped_walk_q;
  assign remain   = remain_q;
  assign ped_pend = ped_pend_q;

endmodule
